// File: rtl/spi_master_link.sv
// SPI mode-0 initiator for 40-bit frames: 8-bit address then 32 data bits, MSB first.
// Generates chip-select, serial clock and MOSI, and captures the 32 data-phase MISO bits.
module spi_master_link #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_cs,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int DW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("spi_master_link: CLK_DIV must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT_HI, SHIFT_LO, TRAIL, GAP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_q, bit_d;
  logic [39:0]   tx_q, tx_d;
  logic [39:0]   rx_q, rx_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic          wrap;

  assign wrap = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = (state_q == IDLE || wrap) ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LEAD;
          tx_d    = {addr, wdata};
          mosi_d  = addr[7];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
        end
      end
      LEAD: begin
        if (wrap) begin
          state_d = SHIFT_HI;
          sclk_d  = 1'b1;
        end
      end
      SHIFT_HI: begin
        // Sample once, on the first high cycle, half a period after the slave's update.
        if (div_q == '0) rx_d = {rx_q[38:0], spi_miso};
        if (wrap) begin
          state_d = SHIFT_LO;
          sclk_d  = 1'b0;
          if (bit_q != 6'd39) begin
            tx_d   = {tx_q[38:0], 1'b0};
            mosi_d = tx_q[38];
          end
        end
      end
      SHIFT_LO: begin
        if (wrap) begin
          if (bit_q == 6'd39) begin
            state_d = TRAIL;
          end else begin
            bit_d   = bit_q + 6'd1;
            state_d = SHIFT_HI;
            sclk_d  = 1'b1;
          end
        end
      end
      TRAIL: begin
        if (wrap) begin
          state_d = GAP;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          rdata_d = rx_q[31:0];
        end
      end
      GAP: begin
        if (wrap) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata    = rdata_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign spi_clk  = sclk_q;
  assign spi_cs   = cs_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_link.sv
// Directed/randomized bench for spi_master_link with a behavioural mode-0 slave model.
// Expected cycle positions come from the frame timing formulas in terms of H.
module tb_spi_master_link;
  localparam int H  = 4;
  localparam int H2 = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        done, busy, spi_clk, spi_cs, spi_mosi;
  logic        spi_miso = 1'b0;

  logic        start2 = 1'b0;
  logic [7:0]  addr2 = '0;
  logic [31:0] wdata2 = '0;
  logic [31:0] rdata2;
  logic        done2, busy2, spi_clk2, spi_cs2, spi_mosi2;
  logic        spi_miso2 = 1'b0;

  int tests = 0;
  int fails = 0;

  spi_master_link #(.CLK_DIV(H)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_master_link #(.CLK_DIV(H2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .done(done2), .busy(busy2), .spi_clk(spi_clk2), .spi_cs(spi_cs2),
    .spi_mosi(spi_mosi2), .spi_miso(spi_miso2)
  );

  always #5 clk = ~clk;

  // Mode-0 slave model: presents its word MSB first, updating on cs fall and each sclk fall.
  logic [39:0] slv_word = '0;
  logic [39:0] slv_sh = '0;
  logic [39:0] mosi_cap = '0;
  int          nrise = 0;
  int          rises = 0;
  int          sclk_edges = 0;

  always @(posedge spi_clk or negedge spi_clk or negedge spi_cs or posedge spi_cs) begin
    if (spi_cs) nrise = 0;
    else if (spi_clk) begin
      rises++;
      nrise++;
      mosi_cap = {mosi_cap[38:0], spi_mosi};
    end else if (nrise == 0) begin
      slv_sh   = slv_word;
      spi_miso = slv_sh[39];
    end else begin
      slv_sh   = slv_sh << 1;
      spi_miso = slv_sh[39];
    end
  end

  always @(spi_clk) sclk_edges++;

  // Second slave: a counter register reading back 0x00001234.
  logic [39:0] slv2_sh = '0;
  logic [39:0] mosi_cap2 = '0;
  int          nrise2 = 0;

  always @(posedge spi_clk2 or negedge spi_clk2 or negedge spi_cs2 or posedge spi_cs2) begin
    if (spi_cs2) nrise2 = 0;
    else if (spi_clk2) begin
      nrise2++;
      mosi_cap2 = {mosi_cap2[38:0], spi_mosi2};
    end else if (nrise2 == 0) begin
      slv2_sh   = {8'h00, 32'h00001234};
      spi_miso2 = slv2_sh[39];
    end else begin
      slv2_sh   = slv2_sh << 1;
      spi_miso2 = slv2_sh[39];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame accepted at cycle 0; optional ignored start pulses at cycles ig1/ig2.
  task automatic do_frame(input logic [7:0] a, input logic [31:0] w, input logic [31:0] r,
                          input int ig1, input int ig2);
    int r0, done_at, ndone, busy_fall, first_rise, cs_rise;
    slv_word = {8'($urandom), r};
    r0 = rises; done_at = -1; ndone = 0; busy_fall = -1; first_rise = -1; cs_rise = -1;
    @(negedge clk);
    start = 1'b1; addr = a; wdata = w;
    @(posedge clk); #1;
    start = 1'b0;
    check("cs_low_c1", spi_cs, 1'b0);
    check("busy_c1", busy, 1'b1);
    check("mosi_c1", spi_mosi, a[7]);
    for (int c = 1; c <= 3 + 83 * H; c++) begin
      if (done) begin ndone++; if (done_at < 0) done_at = c; end
      if (!busy && busy_fall < 0) busy_fall = c;
      if (spi_clk && first_rise < 0) first_rise = c;
      if (spi_cs && cs_rise < 0) cs_rise = c;
      if (c == ig1 || c == ig2) begin
        start = 1'b1; addr = 8'($urandom); wdata = $urandom;
      end else start = 1'b0;
      @(posedge clk); #1;
    end
    check("first_rise", first_rise, 1 + H);
    check("cs_rise", cs_rise, 1 + 82 * H);
    check("done_cycle", done_at, 1 + 82 * H);
    check("done_count", ndone, 1);
    check("busy_fall", busy_fall, 1 + 83 * H);
    check("rise_count", rises - r0, 40);
    check("mosi_stream", mosi_cap, {a, w});
    check("rdata", rdata, r);
    check("mosi_idle", spi_mosi, 1'b0);
    $display("[TB] frame addr=%02h wdata=%08h resp=%08h rdata=%08h done@%0d", a, w, r, rdata, done_at);
  endtask

  initial begin
    int e0, r0, cs_hi, second_fall, ndone;
    logic [7:0]  a;
    logic [31:0] w, r;

    // Reset held from time zero.
    @(negedge clk);
    check("rst_cs", spi_cs, 1'b1);
    check("rst_sclk", spi_clk, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    e0 = sclk_edges;
    repeat (500) @(posedge clk);
    #1;
    check("idle_no_sclk", sclk_edges - e0, 0);
    check("idle_cs", spi_cs, 1'b1);
    $display("[TB] reset/idle checked");

    do_frame(8'h03, 32'hA5A50F0F, 32'hDEADBEEF, -1, -1);
    do_frame(8'($urandom), $urandom, $urandom, 10, 200);
    for (int i = 0; i < 4; i++) do_frame(8'($urandom), $urandom, $urandom, -1, -1);

    // Back-to-back with start held high.
    a = 8'($urandom); w = $urandom; r = 32'hCAFEF00D;
    slv_word = {8'h5A, r};
    r0 = rises; cs_hi = 0; second_fall = -1;
    @(negedge clk);
    start = 1'b1; addr = a; wdata = w;
    @(posedge clk); #1;
    for (int c = 1; c <= 3 + 83 * H; c++) begin
      if (c > 1 && spi_cs && second_fall < 0) cs_hi++;
      if (c > 1 + 82 * H && !spi_cs && second_fall < 0) second_fall = c;
      if (second_fall >= 0) start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("b2b_second_fall", second_fall, 2 + 83 * H);
    check("b2b_cs_high", cs_hi, H + 1);
    for (int i = 0; i < 100 * H && busy; i++) begin @(posedge clk); #1; end
    check("b2b_finished", busy, 1'b0);
    check("b2b_rises", rises - r0, 80);
    check("b2b_mosi", mosi_cap, {a, w});
    check("b2b_rdata", rdata, r);
    $display("[TB] back-to-back second cs fall at %0d, cs high %0d cycles", second_fall, cs_hi);

    // Asynchronous reset at cycle 150 of a frame.
    @(negedge clk);
    start = 1'b1; addr = 8'($urandom); wdata = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (149) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_cs", spi_cs, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_sclk", spi_clk, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 90 * H; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    $display("[TB] mid-frame reset checked");
    do_frame(8'h01, $urandom, $urandom, -1, -1);

    // CLK_DIV=2 instance reading the counter register.
    begin
      int done_at;
      logic [31:0] w2;
      w2 = $urandom;
      done_at = -1;
      @(negedge clk);
      start2 = 1'b1; addr2 = 8'h00; wdata2 = w2;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int c = 1; c <= 3 + 83 * H2; c++) begin
        if (done2 && done_at < 0) done_at = c;
        @(posedge clk); #1;
      end
      check("div2_done", done_at, 1 + 82 * H2);
      check("div2_rdata", rdata2, 32'h00001234);
      check("div2_mosi", mosi_cap2, {8'h00, w2});
      $display("[TB] div2 frame done@%0d rdata=%08h", done_at, rdata2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
